uart_stream_checker: RTL and testbench

//  Synthesisable, parametrised UART stream checker for on-chip/FPGA self-test of the ice51 core.

---
 rtl/uart_stream_checker_if.sv | 32 +++
 rtl/uart_stream_checker.sv | 219 +++++++++++++++++++++
 tb/tb_uart_stream_checker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_stream_checker_if.sv
// Control/status bundle for uart_stream_checker: expected-table write port,
// run start strobe and the result/progress outputs.
interface uart_stream_checker_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              i_exp_we;
  logic [ADDR_W-1:0] i_exp_addr;
  logic [DATA_W+3:0] i_exp_data;
  logic              i_start;
  logic              o_busy;
  logic              o_pass;
  logic              o_fail;
  logic [2:0]        o_fail_code;
  logic [7:0]        o_phase;
  logic              o_phase_done;
  logic [15:0]       o_rx_count;
  logic [DATA_W-1:0] o_got;
  logic [DATA_W-1:0] o_exp;

  modport master (
    output i_exp_we, i_exp_addr, i_exp_data, i_start,
    input  o_busy, o_pass, o_fail, o_fail_code, o_phase, o_phase_done,
           o_rx_count, o_got, o_exp
  );

  modport slave (
    input  i_exp_we, i_exp_addr, i_exp_data, i_start,
    output o_busy, o_pass, o_fail, o_fail_code, o_phase, o_phase_done,
           o_rx_count, o_got, o_exp
  );
endinterface

// File: rtl/uart_stream_checker.sv
// UART stream checker: deserialises a UART TX line and walks a tagged
// expected table (BYTE / PHASE / END), reporting a sticky pass or fail+code.
module uart_stream_checker #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int QUIET_CYC    = 10000
) (
  input logic i_clk,
  input logic i_rst,
  input logic i_uart,
  uart_stream_checker_if.slave sif
);
  localparam logic [3:0] TAG_END = 4'd0, TAG_BYTE = 4'd1, TAG_PHASE = 4'd2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DISP, S_WAIT, S_DRAIN, S_PASS, S_FAIL} st_t;

  // ---------------- receiver ----------------
  logic s1, s2, s3;
  rx_st_t rx_st;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_bit;
  logic [DATA_W-1:0] rx_sh;
  logic rx_valid, rx_ferr, start_det;

  // two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b1; s2 <= 1'b1; s3 <= 1'b1;
    end else begin
      s1 <= i_uart; s2 <= s1; s3 <= s2;
    end
  end

  // falling edge on an idle line; also what DRAIN treats as unwanted traffic
  assign start_det = (rx_st == RX_IDLE) && s3 && !s2;

  // mid-bit sampling deserialiser, free-running regardless of the run FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_st <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
      rx_valid <= 1'b0; rx_ferr <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_st)
        RX_IDLE: if (start_det) begin rx_st <= RX_START; rx_cnt <= '0; end
        RX_START: begin
          if (rx_cnt == 16'(CLKS_PER_BIT/2 - 1)) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt == 16'(CLKS_PER_BIT - 1)) begin
            rx_cnt <= '0;
            rx_sh  <= {s2, rx_sh[DATA_W-1:1]};
            if (rx_bit == 8'(DATA_W - 1)) rx_st <= RX_STOP;
            else rx_bit <= rx_bit + 8'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        default: begin
          if (rx_cnt == 16'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_st    <= RX_IDLE;
            rx_valid <= s2;
            rx_ferr  <= !s2;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
      endcase
    end
  end

  // ---------------- table + run FSM ----------------
  logic [DATA_W+3:0] mem [DEPTH];
  logic [DATA_W+3:0] rd_q;
  st_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_next;
  logic [31:0] timer_q;
  logic busy;
  logic skid_vld, skid_ferr;
  logic [DATA_W-1:0] skid_data;
  logic [3:0] tag;
  logic [DATA_W-1:0] ebyte, ev_data;
  logic ev_ok, ev_ferr, timeout, quiet;
  logic clr, ptr_inc, phase_inc, timer_clr, timer_run, take_rx, set_fail, set_pass;
  logic [2:0] fail_code_d;

  assign busy     = (state_q == S_FETCH) || (state_q == S_DISP) ||
                    (state_q == S_WAIT)  || (state_q == S_DRAIN);
  assign tag      = rd_q[DATA_W+3:DATA_W];
  assign ebyte    = rd_q[DATA_W-1:0];
  assign ptr_next = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign timeout  = (timer_q == 32'(TIMEOUT_CYC - 1));
  assign quiet    = (timer_q == 32'(QUIET_CYC - 1));
  // a frame parked in the skid register takes precedence over the live one
  assign ev_ok    = skid_vld ? !skid_ferr : rx_valid;
  assign ev_ferr  = skid_vld ? skid_ferr  : rx_ferr;
  assign ev_data  = skid_vld ? skid_data  : rx_sh;

  // table RAM: writes locked out during a run, read address follows ptr
  always_ff @(posedge i_clk) begin
    if (sif.i_exp_we && !busy) mem[sif.i_exp_addr] <= sif.i_exp_data;
    rd_q <= mem[ptr_q];
  end

  // catch frames that finish while the FSM is between compares
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      skid_vld <= 1'b0; skid_ferr <= 1'b0; skid_data <= '0;
    end else if (!busy) begin
      skid_vld <= 1'b0;
    end else if ((state_q == S_FETCH || state_q == S_DISP) && (rx_valid || rx_ferr)) begin
      skid_vld <= 1'b1; skid_ferr <= rx_ferr; skid_data <= rx_sh;
    end else if (state_q == S_WAIT) begin
      skid_vld <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: if (sif.i_start) state_d = S_FETCH;
      S_FETCH: state_d = S_DISP;
      S_DISP: begin
        case (tag)
          TAG_END:   state_d = S_DRAIN;
          TAG_BYTE:  state_d = S_WAIT;
          TAG_PHASE: state_d = S_FETCH;
          default:   state_d = S_FAIL;
        endcase
      end
      S_WAIT: begin
        if (ev_ok)                  state_d = (ev_data == ebyte) ? S_FETCH : S_FAIL;
        else if (ev_ferr | timeout) state_d = S_FAIL;
      end
      S_DRAIN: begin
        if (start_det || skid_vld) state_d = S_FAIL;
        else if (quiet)            state_d = S_PASS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output strobes for the datapath
  always_comb begin
    clr = 1'b0; ptr_inc = 1'b0; phase_inc = 1'b0; timer_clr = 1'b0; timer_run = 1'b0;
    take_rx = 1'b0; set_fail = 1'b0; set_pass = 1'b0; fail_code_d = 3'd0;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: clr = sif.i_start;
      S_DISP: begin
        case (tag)
          TAG_END, TAG_BYTE: timer_clr = 1'b1;
          TAG_PHASE: begin phase_inc = 1'b1; ptr_inc = 1'b1; end
          default: begin set_fail = 1'b1; fail_code_d = 3'd5; end
        endcase
      end
      S_WAIT: begin
        timer_run = 1'b1;
        if (ev_ok) begin
          take_rx = 1'b1;
          if (ev_data == ebyte) ptr_inc = 1'b1;
          else begin set_fail = 1'b1; fail_code_d = 3'd1; end
        end else if (ev_ferr) begin set_fail = 1'b1; fail_code_d = 3'd2; end
        else if (timeout)     begin set_fail = 1'b1; fail_code_d = 3'd3; end
      end
      S_DRAIN: begin
        timer_run = 1'b1;
        if (start_det || skid_vld) begin set_fail = 1'b1; fail_code_d = 3'd4; end
        else if (quiet) set_pass = 1'b1;
      end
      default: ;
    endcase
  end

  // datapath / result registers driven by the strobes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0; timer_q <= '0;
      sif.o_pass <= 1'b0; sif.o_fail <= 1'b0; sif.o_fail_code <= '0;
      sif.o_phase <= '0; sif.o_phase_done <= 1'b0; sif.o_rx_count <= '0;
      sif.o_got <= '0; sif.o_exp <= '0;
    end else begin
      sif.o_phase_done <= 1'b0;
      if (clr) begin
        ptr_q <= '0;
        sif.o_pass <= 1'b0; sif.o_fail <= 1'b0; sif.o_fail_code <= '0;
        sif.o_phase <= '0; sif.o_rx_count <= '0; sif.o_got <= '0; sif.o_exp <= '0;
      end
      if (ptr_inc) ptr_q <= ptr_next;
      if (phase_inc) begin
        sif.o_phase      <= sif.o_phase + 8'd1;
        sif.o_phase_done <= 1'b1;
      end
      if (timer_clr)      timer_q <= '0;
      else if (timer_run) timer_q <= timer_q + 32'd1;
      if (take_rx) begin
        sif.o_got <= ev_data;
        sif.o_exp <= ebyte;
        if (sif.o_rx_count != 16'hFFFF) sif.o_rx_count <= sif.o_rx_count + 16'd1;
      end
      if (set_fail) begin sif.o_fail <= 1'b1; sif.o_fail_code <= fail_code_d; end
      if (set_pass) sif.o_pass <= 1'b1;
    end
  end

  assign sif.o_busy = busy;
endmodule

// File: tb/tb_uart_stream_checker.sv
// Scenario bench for uart_stream_checker: fast bit rate, small table and
// short timers; expected run results are queued and compared at run end.
module tb_uart_stream_checker;
  localparam int CPB = 8, DW = 8, DEPTH = 16, AW = 4, TO = 2000, QC = 300;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_uart = 1'b1;
  int checks = 0, failures = 0, pd_total = 0;

  uart_stream_checker_if #(.DATA_W(DW), .ADDR_W(AW)) sif ();

  uart_stream_checker #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW),
                        .TIMEOUT_CYC(TO), .QUIET_CYC(QC))
    dut (.i_clk(i_clk), .i_rst(i_rst), .i_uart(i_uart), .sif(sif));

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (sif.o_phase_done === 1'b1) pd_total++;

  typedef struct packed {
    logic busy, pass, fail;
    logic [2:0] code;
    logic [7:0] phase;
    logic [15:0] cnt;
    logic [7:0] got, exp;
  } res_t;

  res_t sb[$];

  function automatic res_t mk(logic p, logic f, logic [2:0] c, logic [7:0] ph,
                              logic [15:0] n, logic [7:0] g, logic [7:0] e);
    mk = {1'b0, p, f, c, ph, n, g, e};
  endfunction

  function automatic res_t cur();
    cur = {sif.o_busy, sif.o_pass, sif.o_fail, sif.o_fail_code, sif.o_phase,
           sif.o_rx_count, sif.o_got, sif.o_exp};
  endfunction

  task automatic tick(); @(posedge i_clk); #1; endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW+3:0] d);
    sif.i_exp_we = 1'b1; sif.i_exp_addr = a; sif.i_exp_data = d;
    tick();
    sif.i_exp_we = 1'b0;
  endtask

  task automatic start();
    sif.i_start = 1'b1; tick(); sif.i_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stopb);
    i_uart = 1'b0; repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin i_uart = b[i]; repeat (CPB) tick(); end
    i_uart = stopb; repeat (CPB) tick();
    i_uart = 1'b1; repeat (2 * CPB) tick();
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < TO + QC + 500; i++) begin
      @(negedge i_clk);
      if (!sif.o_busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    @(negedge i_clk);
    checks++;
    if (cur() !== '0) begin
      failures++; $display("FAIL reset: got %h want 0", cur());
    end
    i_rst = 1'b0; repeat (2) tick();
  endtask

  task automatic test_pass();
    bit to; res_t r;
    wr(0, {4'd1, 8'h55}); wr(1, {4'd1, 8'hAA}); wr(2, 12'h000);
    start();
    @(negedge i_clk);
    checks++;
    if (sif.o_busy !== 1'b1) begin failures++; $display("FAIL busy_after_start: got %b want 1", sif.o_busy); end
    sb.push_back(mk(1, 0, 0, 0, 2, 8'hAA, 8'hAA));
    send(8'h55, 1); send(8'hAA, 1);
    wait_idle(to); r = sb.pop_front();
    checks++;
    if (to || cur() !== r) begin failures++; $display("FAIL pass: got %h want %h to=%0d", cur(), r, to); end
  endtask

  task automatic test_mismatch();
    bit to; res_t r;
    wr(0, {4'd1, 8'h55}); wr(1, 12'h000);
    start();
    sb.push_back(mk(0, 1, 1, 0, 1, 8'h54, 8'h55));
    send(8'h54, 1);
    wait_idle(to); r = sb.pop_front();
    checks++;
    if (to || cur() !== r) begin failures++; $display("FAIL mismatch: got %h want %h to=%0d", cur(), r, to); end
  endtask

  task automatic test_phase();
    bit to; res_t r; int pd0;
    wr(0, {4'd1, 8'h12}); wr(1, {4'd2, 8'h00}); wr(2, {4'd1, 8'h34}); wr(3, 12'h000);
    pd0 = pd_total;
    start();
    sb.push_back(mk(1, 0, 0, 1, 2, 8'h34, 8'h34));
    send(8'h12, 1); send(8'h34, 1);
    wait_idle(to); r = sb.pop_front();
    checks++;
    if (to || cur() !== r) begin failures++; $display("FAIL phase_run: got %h want %h to=%0d", cur(), r, to); end
    checks++;
    if (pd_total - pd0 != 1) begin failures++; $display("FAIL phase_done_pulses: got %0d want 1", pd_total - pd0); end
  endtask

  task automatic test_unwanted();
    bit to; res_t r;
    wr(0, {4'd1, 8'h12}); wr(1, 12'h000);
    start();
    sb.push_back(mk(0, 1, 4, 0, 1, 8'h12, 8'h12));
    send(8'h12, 1); send(8'h99, 1);
    wait_idle(to); r = sb.pop_front();
    checks++;
    if (to || cur() !== r) begin failures++; $display("FAIL unwanted: got %h want %h to=%0d", cur(), r, to); end
  endtask

  task automatic test_framing();
    bit to; res_t r;
    wr(0, {4'd1, 8'h12}); wr(1, 12'h000);
    start();
    sb.push_back(mk(0, 1, 2, 0, 0, 8'h00, 8'h00));
    send(8'h12, 0);
    wait_idle(to); r = sb.pop_front();
    checks++;
    if (to || cur() !== r) begin failures++; $display("FAIL framing: got %h want %h to=%0d", cur(), r, to); end
  endtask

  task automatic test_timeout();
    bit to; res_t r;
    start();
    sb.push_back(mk(0, 1, 3, 0, 0, 8'h00, 8'h00));
    wait_idle(to); r = sb.pop_front();
    checks++;
    if (to || cur() !== r) begin failures++; $display("FAIL timeout: got %h want %h to=%0d", cur(), r, to); end
  endtask

  task automatic test_reset_mid();
    bit to; res_t r;
    wr(0, {4'd1, 8'hA5}); wr(1, 12'h000);
    start();
    i_uart = 1'b0; repeat (3 * CPB) tick();
    i_rst = 1'b1; tick();
    @(negedge i_clk);
    checks++;
    if (cur() !== '0) begin failures++; $display("FAIL reset_mid: got %h want 0", cur()); end
    i_uart = 1'b1; repeat (3) tick();
    i_rst = 1'b0; repeat (2) tick();
    start();
    sb.push_back(mk(1, 0, 0, 0, 1, 8'hA5, 8'hA5));
    send(8'hA5, 1);
    wait_idle(to); r = sb.pop_front();
    checks++;
    if (to || cur() !== r) begin failures++; $display("FAIL after_reset_run: got %h want %h to=%0d", cur(), r, to); end
  endtask

  task automatic test_bad_tag();
    bit to; res_t r;
    wr(0, {4'd7, 8'h00});
    start();
    sb.push_back(mk(0, 1, 5, 0, 0, 8'h00, 8'h00));
    wait_idle(to); r = sb.pop_front();
    checks++;
    if (to || cur() !== r) begin failures++; $display("FAIL bad_tag: got %h want %h to=%0d", cur(), r, to); end
  endtask

  // writes during a run must be dropped; a second run restarts from clean state
  task automatic test_back_to_back();
    bit to; res_t r;
    wr(0, {4'd1, 8'h12}); wr(1, 12'h000);
    for (int k = 0; k < 2; k++) begin
      start();
      wr(0, {4'd1, 8'h77});
      sb.push_back(mk(1, 0, 0, 0, 1, 8'h12, 8'h12));
      send(8'h12, 1);
      wait_idle(to); r = sb.pop_front();
      checks++;
      if (to || cur() !== r) begin failures++; $display("FAIL back_to_back[%0d]: got %h want %h to=%0d", k, cur(), r, to); end
    end
  endtask

  initial begin
    sif.i_exp_we = 1'b0; sif.i_exp_addr = '0; sif.i_exp_data = '0; sif.i_start = 1'b0;
    test_reset();
    test_pass();         repeat (2 * CPB) tick();
    test_mismatch();     repeat (2 * CPB) tick();
    test_phase();        repeat (2 * CPB) tick();
    test_unwanted();     repeat (2 * CPB) tick();
    test_framing();      repeat (2 * CPB) tick();
    test_timeout();      repeat (2 * CPB) tick();
    test_reset_mid();    repeat (2 * CPB) tick();
    test_bad_tag();      repeat (2 * CPB) tick();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
